axil_dmem_slave: RTL and testbench

AXI4-Lite responder that backs the core's data-memory accesses with a word-organised on-chip RAM. It sits on the slave side of the SoC data bus, opposite the pipeline's memory-stage initiator, and services one write and one read transaction at a time with independent write and read FSMs. Byte strobes give sub-word stores. Out-of-range addresses return SLVERR without touching memory.

---
 rtl/axil_dmem_slave_if.sv | 36 +++
 rtl/axil_dmem_slave.sv | 123 ++++++++++++
 tb/tb_axil_dmem_slave.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_dmem_slave_if.sv
// AXI4-Lite channel bundle between the data-memory responder and its initiator.
interface axil_dmem_slave_if #(
  parameter int unsigned ADDR_WIDTH = 12
);
  logic [ADDR_WIDTH-1:0] s_axi_awaddr;
  logic                  s_axi_awvalid;
  logic                  s_axi_awready;
  logic [31:0]           s_axi_wdata;
  logic [3:0]            s_axi_wstrb;
  logic                  s_axi_wvalid;
  logic                  s_axi_wready;
  logic [1:0]            s_axi_bresp;
  logic                  s_axi_bvalid;
  logic                  s_axi_bready;
  logic [ADDR_WIDTH-1:0] s_axi_araddr;
  logic                  s_axi_arvalid;
  logic                  s_axi_arready;
  logic [31:0]           s_axi_rdata;
  logic [1:0]            s_axi_rresp;
  logic                  s_axi_rvalid;
  logic                  s_axi_rready;

  modport slave (
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

  modport master (
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );
endinterface

// File: rtl/axil_dmem_slave.sv
// AXI4-Lite responder over a word-organised RAM: independent write/read FSMs,
// byte strobes, SLVERR for word indices beyond DEPTH_WORDS.
module axil_dmem_slave #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input logic              clk,
  input logic              rst,
  axil_dmem_slave_if.slave bus
);
  localparam int unsigned WI = ADDR_WIDTH - 2;
  localparam int unsigned IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [WI:0] DEPTH_L     = (WI + 1)'(DEPTH_WORDS);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t wstate, wstate_next;
  rstate_t rstate, rstate_next;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [WI-1:0] aw_word, ar_word;
  logic          aw_in_range, ar_in_range;
  logic          wr_fire, rd_fire;
  logic [1:0]    bresp_q, rresp_q;
  logic [31:0]   rdata_q;
  logic          unused_addr_lsbs;

  assign aw_word     = bus.s_axi_awaddr[ADDR_WIDTH-1:2];
  assign ar_word     = bus.s_axi_araddr[ADDR_WIDTH-1:2];
  assign aw_in_range = {1'b0, aw_word} < DEPTH_L;
  assign ar_in_range = {1'b0, ar_word} < DEPTH_L;
  assign unused_addr_lsbs = ^{bus.s_axi_awaddr[1:0], bus.s_axi_araddr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      wstate <= W_IDLE;
      rstate <= R_IDLE;
    end else begin
      wstate <= wstate_next;
      rstate <= rstate_next;
    end
  end

  // Ready/valid outputs are gated by rst so nothing handshakes during reset.
  always_comb begin
    wstate_next       = wstate;
    wr_fire           = 1'b0;
    bus.s_axi_awready = 1'b0;
    bus.s_axi_wready  = 1'b0;
    bus.s_axi_bvalid  = 1'b0;
    case (wstate)
      W_IDLE: begin
        wr_fire           = bus.s_axi_awvalid && bus.s_axi_wvalid && !rst;
        bus.s_axi_awready = wr_fire;
        bus.s_axi_wready  = wr_fire;
        if (wr_fire) wstate_next = W_RESP;
      end
      W_RESP: begin
        bus.s_axi_bvalid = !rst;
        if (bus.s_axi_bready) wstate_next = W_IDLE;
      end
      default: wstate_next = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_next       = rstate;
    rd_fire           = 1'b0;
    bus.s_axi_arready = 1'b0;
    bus.s_axi_rvalid  = 1'b0;
    case (rstate)
      R_IDLE: begin
        bus.s_axi_arready = !rst;
        rd_fire           = bus.s_axi_arvalid && !rst;
        if (rd_fire) rstate_next = R_DATA;
      end
      R_DATA: begin
        bus.s_axi_rvalid = !rst;
        if (bus.s_axi_rready) rstate_next = R_IDLE;
      end
      default: rstate_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_fire && aw_in_range) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (bus.s_axi_wstrb[i]) mem[aw_word[IW-1:0]][8*i +: 8] <= bus.s_axi_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bresp_q <= RESP_OKAY;
    end else if (wr_fire) begin
      bresp_q <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Same-edge read/write to one word returns the pre-write contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (rd_fire) begin
      if (ar_in_range) begin
        rdata_q <= mem[ar_word[IW-1:0]];
        rresp_q <= RESP_OKAY;
      end else begin
        rdata_q <= '0;
        rresp_q <= RESP_SLVERR;
      end
    end
  end

  assign bus.s_axi_bresp = bresp_q;
  assign bus.s_axi_rdata = rdata_q;
  assign bus.s_axi_rresp = rresp_q;
endmodule

// File: tb/tb_axil_dmem_slave.sv
// Directed plus randomized bench for axil_dmem_slave against an array-based memory model.
module tb_axil_dmem_slave;
  localparam int unsigned AW    = 13;
  localparam int unsigned DEPTH = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axil_dmem_slave_if #(.ADDR_WIDTH(AW)) bus ();
  axil_dmem_slave #(.ADDR_WIDTH(AW), .DEPTH_WORDS(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] ref_mem [int];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit in_range(input logic [AW-1:0] a);
    return (int'(a) / 4) < int'(DEPTH);
  endfunction

  function automatic logic [31:0] expected_read(input logic [AW-1:0] a);
    if (!in_range(a)) return 32'h0;
    return ref_mem.exists(int'(a) / 4) ? ref_mem[int'(a) / 4] : 32'h0;
  endfunction

  function automatic logic [1:0] expected_resp(input logic [AW-1:0] a);
    return in_range(a) ? 2'b00 : 2'b10;
  endfunction

  task automatic model_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    if (!in_range(a)) return;
    w = ref_mem.exists(int'(a) / 4) ? ref_mem[int'(a) / 4] : 32'h0;
    for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    ref_mem[int'(a) / 4] = w;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic write_txn(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    tick();
    bus.s_axi_awaddr = a; bus.s_axi_wdata = d; bus.s_axi_wstrb = s;
    bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1; bus.s_axi_bready = 1'b0;
    mid();
    chk("wr_awready", bus.s_axi_awready, 1);
    chk("wr_wready", bus.s_axi_wready, 1);
    tick();
    bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0; bus.s_axi_bready = 1'b1;
    model_write(a, d, s);
    mid();
    chk("wr_bvalid", bus.s_axi_bvalid, 1);
    chk("wr_bresp", bus.s_axi_bresp, expected_resp(a));
    tick();
    bus.s_axi_bready = 1'b0;
    mid();
    chk("wr_bvalid_clr", bus.s_axi_bvalid, 0);
  endtask

  task automatic read_txn(input logic [AW-1:0] a);
    tick();
    bus.s_axi_araddr = a; bus.s_axi_arvalid = 1'b1; bus.s_axi_rready = 1'b0;
    mid();
    chk("rd_arready", bus.s_axi_arready, 1);
    tick();
    bus.s_axi_arvalid = 1'b0; bus.s_axi_rready = 1'b1;
    mid();
    chk("rd_rvalid", bus.s_axi_rvalid, 1);
    chk("rd_rdata", bus.s_axi_rdata, expected_read(a));
    chk("rd_rresp", bus.s_axi_rresp, expected_resp(a));
    tick();
    bus.s_axi_rready = 1'b0;
    mid();
    chk("rd_rvalid_clr", bus.s_axi_rvalid, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0]   old_val;
    logic [AW-1:0] a;
    logic [31:0]   d;
    logic [3:0]    s;

    // Reset with every valid asserted
    rst = 1'b1;
    bus.s_axi_awaddr = '0; bus.s_axi_wdata = '0; bus.s_axi_wstrb = 4'h0;
    bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1;
    bus.s_axi_araddr = '0; bus.s_axi_arvalid = 1'b1;
    bus.s_axi_bready = 1'b0; bus.s_axi_rready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      mid();
      chk("rst_awready", bus.s_axi_awready, 0);
      chk("rst_wready", bus.s_axi_wready, 0);
      chk("rst_arready", bus.s_axi_arready, 0);
      chk("rst_bvalid", bus.s_axi_bvalid, 0);
      chk("rst_rvalid", bus.s_axi_rvalid, 0);
    end
    chk("rst_bresp", bus.s_axi_bresp, 0);
    chk("rst_rresp", bus.s_axi_rresp, 0);
    chk("rst_rdata", bus.s_axi_rdata, 0);
    tick();
    rst = 1'b0;
    mid();
    chk("post_rst_arready", bus.s_axi_arready, 1);
    chk("post_rst_awready", bus.s_axi_awready, 1);
    chk("post_rst_wready", bus.s_axi_wready, 1);
    tick();
    bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0; bus.s_axi_arvalid = 1'b0;
    bus.s_axi_bready = 1'b1; bus.s_axi_rready = 1'b1;
    model_write('0, 32'h0, 4'h0);
    mid();
    chk("post_rst_bvalid", bus.s_axi_bvalid, 1);
    chk("post_rst_bresp", bus.s_axi_bresp, 0);
    chk("post_rst_rvalid", bus.s_axi_rvalid, 1);
    chk("post_rst_rresp", bus.s_axi_rresp, 0);
    tick();
    bus.s_axi_bready = 1'b0; bus.s_axi_rready = 1'b0;
    mid();
    chk("post_rst_bvalid_clr", bus.s_axi_bvalid, 0);
    chk("post_rst_rvalid_clr", bus.s_axi_rvalid, 0);

    // Full write/read and byte strobes
    write_txn(13'h010, 32'hDEADBEEF, 4'hF);
    read_txn(13'h010);
    write_txn(13'h010, 32'h00001100, 4'b0010);
    read_txn(13'h010);
    chk("strobe_value", expected_read(13'h010), 32'hDEAD11EF);
    read_txn(13'h013);
    write_txn(13'h010, 32'hFFFFFFFF, 4'h0);
    read_txn(13'h010);

    // Range boundaries
    write_txn(13'h000, 32'hA5A5A5A5, 4'hF);
    write_txn(13'h0FFC, 32'h0BADCAFE, 4'hF);
    read_txn(13'h0FFC);
    write_txn(13'h1000, 32'h12345678, 4'hF);
    read_txn(13'h1000);
    read_txn(13'h000);
    read_txn(13'h1FFF);

    // Lone AW waits; B backpressure blocks a second write
    tick();
    bus.s_axi_awaddr = 13'h040; bus.s_axi_wdata = 32'h0BADF00D; bus.s_axi_wstrb = 4'hF;
    bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b0; bus.s_axi_bready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      mid();
      chk("lone_aw_awready", bus.s_axi_awready, 0);
      chk("lone_aw_wready", bus.s_axi_wready, 0);
      tick();
    end
    bus.s_axi_wvalid = 1'b1;
    mid();
    chk("joint_awready", bus.s_axi_awready, 1);
    chk("joint_wready", bus.s_axi_wready, 1);
    tick();
    model_write(13'h040, 32'h0BADF00D, 4'hF);
    bus.s_axi_awaddr = 13'h044; bus.s_axi_wdata = 32'hC0FFEE11;
    for (int c = 0; c < 4; c++) begin
      mid();
      chk("stall_bvalid", bus.s_axi_bvalid, 1);
      chk("stall_bresp", bus.s_axi_bresp, 0);
      chk("stall_awready", bus.s_axi_awready, 0);
      tick();
    end
    bus.s_axi_bready = 1'b1;
    mid();
    chk("stall_release_bvalid", bus.s_axi_bvalid, 1);
    tick();
    bus.s_axi_bready = 1'b0;
    mid();
    chk("second_awready", bus.s_axi_awready, 1);
    tick();
    model_write(13'h044, 32'hC0FFEE11, 4'hF);
    bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0; bus.s_axi_bready = 1'b1;
    mid();
    chk("second_bvalid", bus.s_axi_bvalid, 1);
    tick();
    bus.s_axi_bready = 1'b0;
    read_txn(13'h040);
    read_txn(13'h044);

    // Same-cycle read and write of one word
    write_txn(13'h020, 32'h1, 4'hF);
    tick();
    bus.s_axi_awaddr = 13'h020; bus.s_axi_wdata = 32'h2; bus.s_axi_wstrb = 4'hF;
    bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1;
    bus.s_axi_araddr = 13'h020; bus.s_axi_arvalid = 1'b1;
    mid();
    chk("conc_awready", bus.s_axi_awready, 1);
    chk("conc_arready", bus.s_axi_arready, 1);
    old_val = expected_read(13'h020);
    tick();
    model_write(13'h020, 32'h2, 4'hF);
    bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0; bus.s_axi_arvalid = 1'b0;
    bus.s_axi_bready = 1'b1; bus.s_axi_rready = 1'b1;
    mid();
    chk("conc_rdata_old", bus.s_axi_rdata, old_val);
    chk("conc_rvalid", bus.s_axi_rvalid, 1);
    chk("conc_bvalid", bus.s_axi_bvalid, 1);
    tick();
    bus.s_axi_bready = 1'b0; bus.s_axi_rready = 1'b0;
    read_txn(13'h020);

    // Reset during a stalled read; coinciding write is dropped
    tick();
    bus.s_axi_araddr = 13'h010; bus.s_axi_arvalid = 1'b1; bus.s_axi_rready = 1'b0;
    tick();
    bus.s_axi_arvalid = 1'b0;
    mid();
    chk("pre_rst_rvalid", bus.s_axi_rvalid, 1);
    tick();
    rst = 1'b1;
    bus.s_axi_awaddr = 13'h020; bus.s_axi_wdata = 32'h99; bus.s_axi_wstrb = 4'hF;
    bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1;
    mid();
    chk("mid_rst_rvalid", bus.s_axi_rvalid, 0);
    chk("mid_rst_awready", bus.s_axi_awready, 0);
    tick();
    rst = 1'b0;
    bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
    mid();
    chk("after_rst_rvalid", bus.s_axi_rvalid, 0);
    chk("after_rst_bvalid", bus.s_axi_bvalid, 0);
    chk("after_rst_arready", bus.s_axi_arready, 1);
    chk("after_rst_rdata", bus.s_axi_rdata, 0);
    read_txn(13'h020);

    // Randomized traffic over a pool of fully initialised words
    for (int k = 0; k < 8; k++) write_txn(AW'(13'h100 + 4 * k), $urandom, 4'hF);
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) a = AW'(13'h1000 + $urandom_range(0, 13'hFFF));
      else a = AW'(13'h100 + 4 * $urandom_range(0, 7) + $urandom_range(0, 3));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) write_txn(a, d, s);
      else read_txn(a);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
